// File: rtl/aes_trace_uart_tx.sv
// Snapshots the AES result on every busy 1->0 edge and streams it as an 8N1 UART frame (SYNC + 16 bytes).
// Build option AES_TRACE_CHECKSUM_EN appends an XOR checksum byte of the 16 data bytes.
module aes_trace_uart_tx #(
   parameter int unsigned CLKS_PER_BIT = 104,
   parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
   input  logic         ICE_CLK,
   input  logic         resetn,
   input  logic         aes_busy_i,
   input  logic [127:0] data_i,
   output logic         uart_tx_o,
   output logic         tx_active_o,
   output logic         overrun_o,
   output logic [7:0]   frame_count_o
);
   localparam int DATA_W = 128;
`ifdef AES_TRACE_CHECKSUM_EN
   localparam int FRAME_BYTES = 18;
`else
   localparam int FRAME_BYTES = 17;
`endif
   localparam int          BUF_W     = FRAME_BYTES * 8;
   localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
   localparam logic [4:0]  BYTE_LAST = 5'(FRAME_BYTES - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t           state, state_nxt;
   logic [15:0]      timer, timer_nxt;
   logic [2:0]       bit_idx, bit_nxt;
   logic [4:0]       byte_idx, byte_nxt;
   logic [BUF_W-1:0] shift_buf, buf_nxt;
   logic [7:0]       cur_byte_nxt;
   logic [7:0]       count_nxt;
   logic             busy_q, done, frame_done, overrun_nxt, tx_d, active_d;

`ifdef AES_TRACE_CHECKSUM_EN
   function automatic logic [7:0] xor_bytes(input logic [DATA_W-1:0] d);
      logic [7:0] acc;
      acc = '0;
      for (int i = 0; i < DATA_W / 8; i++) acc ^= d[i*8 +: 8];
      return acc;
   endfunction

   function automatic logic [BUF_W-1:0] frame_image(input logic [DATA_W-1:0] d);
      return {SYNC_BYTE, d, xor_bytes(d)};
   endfunction
`else
   function automatic logic [BUF_W-1:0] frame_image(input logic [DATA_W-1:0] d);
      return {SYNC_BYTE, d};
   endfunction
`endif

   assign done = busy_q & ~aes_busy_i;

   always_ff @(posedge ICE_CLK) begin
      if (!resetn) begin
         state         <= IDLE;
         timer         <= '0;
         bit_idx       <= '0;
         byte_idx      <= '0;
         shift_buf     <= '0;
         busy_q        <= 1'b0;
         uart_tx_o     <= 1'b1;
         tx_active_o   <= 1'b0;
         overrun_o     <= 1'b0;
         frame_count_o <= '0;
      end else begin
         state         <= state_nxt;
         timer         <= timer_nxt;
         bit_idx       <= bit_nxt;
         byte_idx      <= byte_nxt;
         shift_buf     <= buf_nxt;
         busy_q        <= aes_busy_i;
         uart_tx_o     <= tx_d;
         tx_active_o   <= active_d;
         overrun_o     <= overrun_nxt;
         frame_count_o <= count_nxt;
      end
   end

   // The bit timer restarts on every state entry; the frame buffer shifts one byte per STOP->START.
   always_comb begin
      state_nxt  = state;
      timer_nxt  = timer + 16'd1;
      bit_nxt    = bit_idx;
      byte_nxt   = byte_idx;
      buf_nxt    = shift_buf;
      frame_done = 1'b0;
      if (state == IDLE) begin
         timer_nxt = '0;
         if (done && !tx_active_o) begin
            state_nxt = START;
            bit_nxt   = '0;
            byte_nxt  = '0;
            buf_nxt   = frame_image(data_i);
         end
      end else if (timer == BIT_LAST) begin
         timer_nxt = '0;
         case (state)
            START: begin
               state_nxt = DATA;
               bit_nxt   = '0;
            end
            DATA: begin
               if (bit_idx == 3'd7) state_nxt = STOP;
               else                 bit_nxt   = bit_idx + 3'd1;
            end
            STOP: begin
               if (byte_idx == BYTE_LAST) begin
                  state_nxt  = IDLE;
                  frame_done = 1'b1;
               end else begin
                  state_nxt = START;
                  byte_nxt  = byte_idx + 5'd1;
                  buf_nxt   = shift_buf << 8;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Line level is derived from the next state so the pin register leads with no input-to-pin path.
   always_comb begin
      tx_d         = 1'b1;
      cur_byte_nxt = buf_nxt[BUF_W-1 -: 8];
      active_d     = (state_nxt != IDLE);
      overrun_nxt  = overrun_o | (done & tx_active_o);
      count_nxt    = frame_count_o + {7'd0, frame_done};
      case (state_nxt)
         START:   tx_d = 1'b0;
         DATA:    tx_d = cur_byte_nxt[bit_nxt];
         default: tx_d = 1'b1;
      endcase
   end
endmodule

// File: tb/tb_aes_trace_uart_tx.sv
// Bench for aes_trace_uart_tx: decodes the serial line and compares against a byte-level frame model.
module tb_aes_trace_uart_tx;
   localparam int CPB = 4;
`ifdef AES_TRACE_CHECKSUM_EN
   localparam int NB = 18;
`else
   localparam int NB = 17;
`endif
   localparam int FB   = NB * 10 * CPB;
   localparam int CPB2 = 2;
   localparam int FB2  = NB * 10 * CPB2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic resetn, busy, tx, act, ovr;
   logic [127:0] data;
   logic [7:0] cnt;
   logic resetn2, busy2, tx2, act2, ovr2;
   logic [127:0] data2;
   logic [7:0] cnt2;

   aes_trace_uart_tx #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5)) dut (
      .ICE_CLK(clk), .resetn(resetn), .aes_busy_i(busy), .data_i(data),
      .uart_tx_o(tx), .tx_active_o(act), .overrun_o(ovr), .frame_count_o(cnt));

   aes_trace_uart_tx #(.CLKS_PER_BIT(CPB2), .SYNC_BYTE(8'hA5)) dut2 (
      .ICE_CLK(clk), .resetn(resetn2), .aes_busy_i(busy2), .data_i(data2),
      .uart_tx_o(tx2), .tx_active_o(act2), .overrun_o(ovr2), .frame_count_o(cnt2));

   int vecs = 0;
   int errs = 0;
   bit tx_log[$];
   bit act_log[$];
   int cyc = -1;

   typedef struct {
      logic [127:0] data;
      logic [7:0]   b1;
      logic [7:0]   b16;
      logic [7:0]   csum;
   } vec_t;
   vec_t tbl[3];

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      vecs++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      tx_log.push_back(tx);
      act_log.push_back(act);
      cyc = tx_log.size() - 1;
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   task automatic run_to(input int idx);
      while (cyc < idx) tick();
   endtask

   function automatic logic [7:0] model_byte(input logic [127:0] d, input int b);
      logic [7:0] x;
      x = 8'h00;
      if (b == 0) return 8'hA5;
      if (b <= 16) return d[(16 - b) * 8 +: 8];
      for (int i = 0; i < 16; i++) x ^= d[i*8 +: 8];
      return x;
   endfunction

   // Ten mid-bit samples of character b of the frame whose start bit begins at log index s.
   function automatic logic [9:0] char_at(input int s, input int b);
      logic [9:0] c;
      for (int k = 0; k < 10; k++) c[k] = tx_log[s + b*10*CPB + k*CPB + CPB/2];
      return c;
   endfunction

   task automatic complete(input logic [127:0] d, output int s);
      busy = 1'b1;
      tick();
      busy = 1'b0;
      data = d;
      tick();
      s = cyc;
   endtask

   task automatic check_frame(input string name, input int s, input logic [127:0] d);
      int n;
      int i;
      check($sformatf("%s start_bit", name), tx_log[s], 1'b0);
      check($sformatf("%s pre_idle", name), act_log[s-1], 1'b0);
      for (int b = 0; b < NB; b++)
         check($sformatf("%s byte%0d", name, b), char_at(s, b), {1'b1, model_byte(d, b), 1'b0});
      n = 0;
      i = s;
      while (i < act_log.size() && act_log[i]) begin
         n++;
         i++;
      end
      check($sformatf("%s active_len", name), n, FB);
   endtask

   task automatic main_seq();
      int s, s2, ones, exp_cnt;
      bit exp_ovr;
      logic [9:0] c;
      logic [127:0] d;

      ones = 0;
      run(60);
      for (int i = cyc - 59; i <= cyc; i++) ones += int'(act_log[i]) + int'(!tx_log[i]);
      check("startup no_activity", ones, 0);
      check("startup count", cnt, 8'd0);

      for (int i = 0; i < 3; i++) begin
         complete(tbl[i].data, s);
         check($sformatf("tbl%0d latency_tx", i), tx, 1'b0);
         check($sformatf("tbl%0d latency_act", i), act, 1'b1);
         run_to(s + FB + 2);
         check_frame($sformatf("tbl%0d", i), s, tbl[i].data);
         c = char_at(s, 1);
         check($sformatf("tbl%0d b1", i), c[8:1], tbl[i].b1);
         c = char_at(s, 16);
         check($sformatf("tbl%0d b16", i), c[8:1], tbl[i].b16);
`ifdef AES_TRACE_CHECKSUM_EN
         c = char_at(s, 17);
         check($sformatf("tbl%0d csum", i), c[8:1], tbl[i].csum);
`endif
         check($sformatf("tbl%0d count", i), cnt, 8'(i + 1));
         check($sformatf("tbl%0d overrun", i), ovr, 1'b0);
      end

      // Second completion while the first frame is in flight.
      complete(128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D, s);
      run_to(s + 298);
      busy = 1'b1;
      tick();
      busy = 1'b0;
      data = 128'h11111111_22222222_33333333_44444444;
      check("ovr before", ovr, 1'b0);
      tick();
      check("ovr after", ovr, 1'b1);
      run_to(s + FB + 2);
      check_frame("ovr frame", s, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D);
      check("ovr count", cnt, 8'd4);
      run(20);
      check("ovr sticky", ovr, 1'b1);
      check("ovr idle", act, 1'b0);

      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      check("rst1 ovr", ovr, 1'b0);
      check("rst1 cnt", cnt, 8'd0);

      // Completion one cycle after the final stop bit is accepted.
      complete(128'h0F0E0D0C_0B0A0908_07060504_03020100, s);
      run_to(s + FB - 2);
      busy = 1'b1;
      tick();
      check("bnd last_active", act, 1'b1);
      tick();
      check("bnd idle", act, 1'b0);
      check("bnd cnt1", cnt, 8'd1);
      busy = 1'b0;
      data = 128'h5A5A5A5A_A5A5A5A5_C3C3C3C3_3C3C3C3C;
      tick();
      s2 = cyc;
      check("bnd accept_tx", tx, 1'b0);
      check("bnd accept_act", act, 1'b1);
      check("bnd accept_ovr", ovr, 1'b0);
      check_frame("bnd f1", s, 128'h0F0E0D0C_0B0A0908_07060504_03020100);
      run_to(s2 + FB - 2);
      busy = 1'b1;
      tick();
      check("bnd drop_in_last", act, 1'b1);
      busy = 1'b0;
      data = 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF;
      tick();
      check("bnd drop_act", act, 1'b0);
      check("bnd drop_ovr", ovr, 1'b1);
      check("bnd drop_tx", tx, 1'b1);
      check("bnd cnt2", cnt, 8'd2);
      run(10);
      check("bnd stays_idle", act, 1'b0);
      check_frame("bnd f2", s2, 128'h5A5A5A5A_A5A5A5A5_C3C3C3C3_3C3C3C3C);

      // Reset in the middle of byte 5.
      complete(128'h00112233_44556677_8899AABB_CCDDEEFF, s);
      run_to(s + 5*10*CPB + 6);
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      check("mid_rst tx", tx, 1'b1);
      check("mid_rst act", act, 1'b0);
      check("mid_rst cnt", cnt, 8'd0);
      check("mid_rst ovr", ovr, 1'b0);
      run(10);
      complete(128'h13579BDF_2468ACE0_FEDCBA98_76543210, s);
      run_to(s + FB + 2);
      check_frame("post_rst", s, 128'h13579BDF_2468ACE0_FEDCBA98_76543210);
      check("post_rst cnt", cnt, 8'd1);

      exp_cnt = 1;
      exp_ovr = 1'b0;
      for (int r = 0; r < 6; r++) begin
         int off;
         d = {$urandom, $urandom, $urandom, $urandom};
         run($urandom_range(1, 20));
         complete(d, s);
         if ($urandom_range(0, 1) == 1) begin
            off = $urandom_range(2, FB - 3);
            run_to(s + off - 1);
            busy = 1'b1;
            tick();
            busy = 1'b0;
            data = ~d;
            exp_ovr = 1'b1;
         end
         run_to(s + FB + 2);
         exp_cnt++;
         check_frame($sformatf("rnd%0d", r), s, d);
         check($sformatf("rnd%0d cnt", r), cnt, 8'(exp_cnt));
         check($sformatf("rnd%0d ovr", r), ovr, exp_ovr);
      end
   endtask

   task automatic wrap_seq();
      int w;
      for (int f = 0; f < 256; f++) begin
         busy2 = 1'b1;
         @(posedge clk);
         #1;
         busy2 = 1'b0;
         data2 = {$urandom, $urandom, $urandom, $urandom};
         @(posedge clk);
         #1;
         w = 0;
         while (act2 && w < FB2 + 10) begin
            @(posedge clk);
            #1;
            w++;
         end
         check($sformatf("wrap%0d span", f), w, FB2);
         if (w != FB2) break;
         if (f == 0)   check("wrap count1", cnt2, 8'd1);
         if (f == 254) check("wrap count255", cnt2, 8'd255);
      end
      check("wrap count0", cnt2, 8'd0);
      check("wrap ovr", ovr2, 1'b0);
   endtask

   initial begin
      tbl[0] = '{128'h00112233_44556677_8899AABB_CCDDEEFF, 8'h00, 8'hFF, 8'h00};
      tbl[1] = '{128'h00000000_00000000_00000000_00000001, 8'h00, 8'h01, 8'h01};
      tbl[2] = '{128'hFF000000_00000000_00000000_00000080, 8'hFF, 8'h80, 8'h7F};

      resetn  = 1'b0;
      busy    = 1'b0;
      data    = '0;
      resetn2 = 1'b0;
      busy2   = 1'b0;
      data2   = '0;
      run(3);
      check("reset tx", tx, 1'b1);
      check("reset act", act, 1'b0);
      check("reset ovr", ovr, 1'b0);
      check("reset cnt", cnt, 8'd0);
      resetn  = 1'b1;
      resetn2 = 1'b1;
      fork
         main_seq();
         wrap_seq();
      join
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
